// File: rtl/key_press_gen.sv
`default_nettype none
// ============================================================================
//  Module      : key_press_gen
//  Description : Deterministic push-button emulator. On a request it drives an
//                active-low key line: bounce at the press edge, stable low
//                hold, bounce at the release edge, then a stable high settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_press_gen #(
    parameter logic [27:0] FREQ         = 28'd50_000_000,
    parameter int          HOLD_MS      = 20,
    parameter int          BOUNCE_EDGES = 4,
    parameter int          GLITCH_CYC   = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        press_req,
    input  logic        abort,
    output logic        key_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] press_cnt
);

    localparam logic [31:0] c_HOLD_CYC   = 32'((32'(FREQ) / 32'd1000) * 32'(HOLD_MS));
    localparam logic [31:0] c_GLITCH_CYC = 32'(GLITCH_CYC);
    localparam logic [31:0] c_LAST_SEG   = (BOUNCE_EDGES > 0) ? 32'(2 * BOUNCE_EDGES - 1) : 32'd0;
    localparam logic        c_HAS_BOUNCE = (BOUNCE_EDGES > 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESS_B = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_REL_B   = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;

    // Phases that are empty for this parameter set are skipped at elaboration
    // time, so the FSM never spends a cycle in a zero-length phase.
    localparam logic [2:0] c_AFTER_HOLD = c_HAS_BOUNCE ? S_REL_B : S_SETTLE;
    localparam logic [2:0] c_HOLD_ENTRY = (c_HOLD_CYC != 32'd0) ? S_HOLD : c_AFTER_HOLD;
    localparam logic [2:0] c_START      = c_HAS_BOUNCE ? S_PRESS_B : c_HOLD_ENTRY;

    logic [2:0]  r_state;
    logic [31:0] r_seg_cnt;
    logic [31:0] r_seg_idx;
    logic        r_key_out;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_press_cnt;

    // Key level on the first cycle of a phase: press side low, release side high.
    function automatic logic f_entry_level(input logic [2:0] s);
        return (s == S_REL_B) || (s == S_SETTLE);
    endfunction

    assign key_out   = r_key_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign press_cnt = r_press_cnt;

    // Sequencer: phase/segment tracking with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_seg_cnt   <= 32'd0;
            r_seg_idx   <= 32'd0;
            r_key_out   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_press_cnt <= 16'd0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state   <= S_IDLE;
                r_key_out <= 1'b1;
                r_busy    <= 1'b0;
                r_seg_cnt <= 32'd0;
                r_seg_idx <= 32'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Abort in the same cycle drops the request.
                        if (press_req && !abort) begin
                            r_state   <= c_START;
                            r_key_out <= f_entry_level(c_START);
                            r_busy    <= 1'b1;
                            r_seg_cnt <= 32'd1;
                            r_seg_idx <= 32'd0;
                        end
                    end
                    S_PRESS_B: begin
                        if (r_seg_cnt == c_GLITCH_CYC) begin
                            r_seg_cnt <= 32'd1;
                            if (r_seg_idx == c_LAST_SEG) begin
                                r_state   <= c_HOLD_ENTRY;
                                r_key_out <= f_entry_level(c_HOLD_ENTRY);
                                r_seg_idx <= 32'd0;
                            end else begin
                                // Even segments low, odd segments high.
                                r_seg_idx <= r_seg_idx + 32'd1;
                                r_key_out <= ~r_seg_idx[0];
                            end
                        end else begin
                            r_seg_cnt <= r_seg_cnt + 32'd1;
                        end
                    end
                    S_HOLD: begin
                        if (r_seg_cnt == c_HOLD_CYC) begin
                            r_state   <= c_AFTER_HOLD;
                            r_key_out <= f_entry_level(c_AFTER_HOLD);
                            r_seg_cnt <= 32'd1;
                            r_seg_idx <= 32'd0;
                        end else begin
                            r_seg_cnt <= r_seg_cnt + 32'd1;
                        end
                    end
                    S_REL_B: begin
                        if (r_seg_cnt == c_GLITCH_CYC) begin
                            r_seg_cnt <= 32'd1;
                            if (r_seg_idx == c_LAST_SEG) begin
                                r_state   <= S_SETTLE;
                                r_key_out <= 1'b1;
                                r_seg_idx <= 32'd0;
                            end else begin
                                // Even segments high, odd segments low.
                                r_seg_idx <= r_seg_idx + 32'd1;
                                r_key_out <= r_seg_idx[0];
                            end
                        end else begin
                            r_seg_cnt <= r_seg_cnt + 32'd1;
                        end
                    end
                    S_SETTLE: begin
                        if (r_seg_cnt == c_GLITCH_CYC) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_press_cnt <= r_press_cnt + 16'd1;
                            r_seg_cnt   <= 32'd0;
                        end else begin
                            r_seg_cnt <= r_seg_cnt + 32'd1;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_key_out <= 1'b1;
                        r_busy    <= 1'b0;
                        r_seg_cnt <= 32'd0;
                        r_seg_idx <= 32'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
